fetch_prefetch_unit: RTL and testbench

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

---
 rtl/fetch_prefetch_unit_pkg.sv | 23 ++
 rtl/fetch_prefetch_unit_if.sv | 31 +++
 rtl/fetch_prefetch_unit_fifo.sv | 58 +++++
 rtl/fetch_prefetch_unit.sv | 84 ++++++++
 tb/tb_fetch_prefetch_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// rtl/fetch_prefetch_unit_pkg.sv - shared pipeline constants and types for the fetch/prefetch unit
// Contents: XLEN, NOP encoding, RESET_PC/IMEM_WORDS defaults, the queue entry type,
// and the wrapped next-PC helper.
package pipeline_pkg;

    localparam int               XLEN               = 32;
    localparam logic [XLEN-1:0]  NOP                = 32'h0000_0000;
    localparam logic [XLEN-1:0]  RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int               IMEM_WORDS_DEFAULT = 1024;

    // One prefetch queue entry: instruction plus the byte address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instn;
    } fetch_entry_t;

    // Sequential PC with wrap to the instruction memory size; mask = bytes-1.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc,
                                                input logic [XLEN-1:0] mask);
        return (pc + XLEN'(4)) & mask;
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// rtl/fetch_prefetch_unit_if.sv - instruction memory and decode-side bundle of the fetch/prefetch unit
// Signals: imem_req/imem_addr/imem_data (instruction memory), stall/redirect/redirect_pc
// (from the pipeline), valid/instn/pc_out/pc_plus4 (to decode).
// master = fetch unit side, slave = memory/pipeline side.
interface fetch_prefetch_unit_if
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_data;
    logic              stall;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              valid;
    logic [XLEN-1:0]   instn;
    logic [XLEN-1:0]   pc_out;
    logic [XLEN-1:0]   pc_plus4;

    modport master (
        output imem_req, imem_addr, valid, instn, pc_out, pc_plus4,
        input  imem_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, valid, instn, pc_out, pc_plus4,
        output imem_data, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_prefetch_unit_fifo.sv
// rtl/fetch_prefetch_unit_fifo.sv - prefetch queue of {pc, instn} entries with flush
// Ports: clk, reset (async active-low), push/push_data, pop, flush, head (entry at read
// pointer), count (occupancy 0..DEPTH). Caller guarantees no push when full, no pop when empty.
module prefetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch with prefetch queue, redirect flush and stall hold
// Ports: clk, reset (async active-low), bus (fetch_prefetch_unit_if.master):
//   imem_req/imem_addr out, imem_data in (one cycle after request),
//   stall/redirect/redirect_pc in, valid/instn/pc_out/pc_plus4 out (queue head).
module fetch_prefetch_unit
    import pipeline_pkg::*;
#(
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_prefetch_unit_if.master  bus
);

    localparam int              ADDR_W     = $clog2(IMEM_WORDS);
    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_MASK    = XLEN'(IMEM_WORDS * 4 - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = PC_MASK & ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            fetch_go;
    logic            push;
    logic            pop;
    logic            queue_valid;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // Queue slots are reserved at request time, so a response always finds room.
    always_comb begin
        occupancy   = {1'b0, count} + (CW+1)'(inflight);
        fetch_go    = reset && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
        queue_valid = (count != '0);
        // A response landing in a redirect cycle belongs to the old stream.
        push        = inflight && !bus.redirect;
        pop         = queue_valid && !bus.stall && !bus.redirect;
        push_data.pc    = req_pc;
        push_data.instn = bus.imem_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc & ALIGN_MASK;
            inflight <= 1'b0;
        end else begin
            inflight <= fetch_go;
            if (fetch_go) begin
                req_pc   <= fetch_pc;
                fetch_pc <= pc_next(fetch_pc, PC_MASK);
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.redirect),
        .head      (head),
        .count     (count)
    );

    // Outputs come only from registered state, never straight from imem_data.
    assign bus.imem_req  = fetch_go;
    assign bus.imem_addr = fetch_pc[ADDR_W+1:2];
    assign bus.valid     = queue_valid;
    assign bus.instn     = queue_valid ? head.instn          : NOP;
    assign bus.pc_out    = queue_valid ? head.pc             : '0;
    assign bus.pc_plus4  = queue_valid ? head.pc + XLEN'(4)  : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fetch_prefetch_unit_if #(.ADDR_W(10)) bus ();

    fetch_prefetch_unit #(
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at byte address A holds 0x1300_0000 + A, one cycle after request.
    always @(posedge clk) begin
        if (bus.imem_req) begin
            bus.imem_data <= 32'h1300_0000 + {20'd0, bus.imem_addr, 2'b00};
        end else begin
            bus.imem_data <= 32'hDEAD_BEEF;
        end
    end

    // Leaves the bench at the negedge where reset was just released (cycle 0).
    task automatic restart(input logic stall_v);
        @(negedge clk);
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.stall       = stall_v;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({bus.valid, bus.imem_req} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: valid,imem_req=%b%b required 00", bus.valid, bus.imem_req);
        end
        checks++;
        if ({bus.instn, bus.pc_out, bus.pc_plus4} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: instn=%h pc_out=%h pc_plus4=%h required all 0",
                     bus.instn, bus.pc_out, bus.pc_plus4);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 10'h000}) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h required 1 000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_stream;
        restart(1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (bus.valid !== (k >= 2)) begin
                errors++;
                $display("FAIL stream_valid cycle %0d: got %b required %b", k, bus.valid, (k >= 2));
            end
            if (k >= 2) begin
                checks++;
                if ({bus.pc_out, bus.pc_plus4, bus.instn} !==
                    {32'((k-2)*4), 32'((k-1)*4), 32'h1300_0000 + 32'((k-2)*4)}) begin
                    errors++;
                    $display("FAIL stream_head cycle %0d: pc=%h pc4=%h instn=%h required pc=%h",
                             k, bus.pc_out, bus.pc_plus4, bus.instn, 32'((k-2)*4));
                end
            end else begin
                checks++;
                if (bus.instn !== 32'h0) begin
                    errors++;
                    $display("FAIL stream_nop cycle %0d: instn=%h required 0", k, bus.instn);
                end
            end
        end
    endtask

    task automatic test_stall;
        int nreq;
        nreq = 0;
        restart(1'b1);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.imem_req) nreq++;
            if (k >= 2) begin
                checks++;
                if ({bus.valid, bus.pc_out, bus.instn} !== {1'b1, 32'h0, 32'h1300_0000}) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d: valid=%b pc=%h instn=%h required 1 0 13000000",
                             k, bus.valid, bus.pc_out, bus.instn);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (nreq !== 4) begin
            errors++;
            $display("FAIL stall_req_count: got %0d required 4", nreq);
        end
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_low: imem_req=%b required 0", bus.imem_req);
        end
        bus.stall = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 32'h4) begin
            errors++;
            $display("FAIL stall_release: pc_out=%h required 4", bus.pc_out);
        end
    endtask

    task automatic test_redirect;
        restart(1'b1);
        repeat (3) @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_req_low: imem_req=%b required 0", bus.imem_req);
        end
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        #1;
        checks++;
        if ({bus.valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 10'h040}) begin
            errors++;
            $display("FAIL redirect_refetch: valid=%b req=%b addr=%h required 0 1 040",
                     bus.valid, bus.imem_req, bus.imem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_gap: valid=%b required 0", bus.valid);
        end
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.pc_out, bus.pc_plus4, bus.instn} !==
            {1'b1, 32'h100, 32'h104, 32'h1300_0100}) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h pc4=%h instn=%h required 1 100 104 13000100",
                     bus.valid, bus.pc_out, bus.pc_plus4, bus.instn);
        end
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 32'h104) begin
            errors++;
            $display("FAIL redirect_next: pc_out=%h required 104", bus.pc_out);
        end
    endtask

    task automatic test_redirect_stall;
        restart(1'b0);
        repeat (5) @(negedge clk);
        bus.redirect    = 1'b1;
        bus.stall       = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        checks++;
        if ({bus.valid, bus.pc_out} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rs_flush: valid=%b pc=%h required 0 0", bus.valid, bus.pc_out);
        end
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL rs_gap: valid=%b pc=%h required valid 0", bus.valid, bus.pc_out);
        end
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.pc_out, bus.instn} !== {1'b1, 32'h200, 32'h1300_0200}) begin
            errors++;
            $display("FAIL rs_target: valid=%b pc=%h instn=%h required 1 200 13000200",
                     bus.valid, bus.pc_out, bus.instn);
        end
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 32'h204) begin
            errors++;
            $display("FAIL rs_next: pc_out=%h required 204", bus.pc_out);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFC;
        exp_pc[1] = 32'h000;
        exp_pc[2] = 32'h004;
        restart(1'b0);
        repeat (3) @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0FFC;
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        checks++;
        if (bus.imem_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL wrap_addr: imem_addr=%h required 3ff", bus.imem_addr);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.valid, bus.pc_out, bus.instn} !== {1'b1, exp_pc[i], 32'h1300_0000 + exp_pc[i]}) begin
                errors++;
                $display("FAIL wrap_seq %0d: valid=%b pc=%h instn=%h required pc=%h",
                         i, bus.valid, bus.pc_out, bus.instn, exp_pc[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        restart(1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ({bus.valid, bus.imem_req} !== 2'b10) begin
            errors++;
            $display("FAIL ar_full: valid=%b req=%b required 1 0", bus.valid, bus.imem_req);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.valid, bus.imem_req, bus.instn, bus.pc_out} !== {2'b00, 64'h0}) begin
            errors++;
            $display("FAIL ar_drop: valid=%b req=%b instn=%h pc=%h required 0 0 0 0",
                     bus.valid, bus.imem_req, bus.instn, bus.pc_out);
        end
        @(negedge clk);
        bus.stall = 1'b0;
        reset     = 1'b1;
        #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 10'h000}) begin
            errors++;
            $display("FAIL ar_restart_req: req=%b addr=%h required 1 000", bus.imem_req, bus.imem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.valid, bus.pc_out} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL ar_restart_head: valid=%b pc=%h required 1 0", bus.valid, bus.pc_out);
        end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        reset           = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
